joystick_adc_scheduler: RTL and testbench
=========================================

Name: joystick_adc_scheduler

Overview:
Sequences a shared external 10-bit SPI ADC (MCP3008-style, 8 single-ended channels) to sample the joystick X and Y axes.
- Each round converts X, then Y, and publishes them together as a coherent pair.
- Rounds are started by a periodic sample timer or an on-demand trigger.
- Sits between the board ADC pins and the joystick consumer logic, replacing direct analog sampling.

Parameters:
- CLK_DIV, 8: clk cycles per SCLK half-period. Legal minimum is 3.
- SAMPLE_PERIOD, 50000: clk cycles between timer ticks. Legal minimum is 80*CLK_DIV.
- CH_X, 0: ADC channel number for the X axis (3 bits).
- CH_Y, 1: ADC channel number for the Y axis (3 bits).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset (see below).
- enable, in, 1: enables the periodic timer.
- trigger, in, 1: one-cycle request for an immediate round.
- adc_cs_n, out, 1: ADC chip select, active-low.
- adc_sclk, out, 1: SPI clock, mode 0.
- adc_mosi, out, 1: command bits to the ADC.
- adc_miso, in, 1: data from the ADC; asynchronous to clk.
- digital_x, out, 10: last X result.
- digital_y, out, 10: last Y result.
- sample_valid, out, 1: one-cycle pulse when digital_x/digital_y update.
- busy, out, 1: high while a round is in progress.
- overrun, out, 1: sticky flag, set when a start request is lost.

Reset and clock: reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Reset values: adc_cs_n=1, adc_sclk=0, adc_mosi=0, digital_x=0, digital_y=0, sample_valid=0, busy=0, overrun=0. Timer and pending flag are cleared.
- Reset mid-frame: cs_n goes high and sclk goes low immediately. The partial result is discarded.
- adc_miso passes through a 2-flop synchronizer before use.

Timer:
- Counts while enable=1 and emits a tick every SAMPLE_PERIOD cycles.
- When enable=0, the counter holds at 0 and no ticks are emitted.
- An in-progress round always completes, regardless of enable.

Start events (tick or trigger):
- In IDLE: the round starts.
- While busy: the event sets a one-deep pending flag. If pending is already set, overrun is set instead.
- A tick and a trigger in the same cycle count as one event.
- A pending event starts a new round on the cycle after sample_valid.

Round FSM, states IDLE, CS_SETUP, SHIFT, CS_HOLD, PUBLISH:
- The start event is seen at cycle t0. busy=1 from t0+1 until PUBLISH inclusive.
- CS_SETUP: cs_n falls at t0+1; sclk stays low for CLK_DIV cycles.
- SHIFT: sclk toggles every CLK_DIV cycles, 32 toggles, rising first, ending low.
- MOSI:
  - Presents frame bits 1 (start), 1 (single-ended), D2, D1, D0, then 0.
  - Bit 1 is valid from the cs_n fall.
  - Each later bit changes with an sclk falling edge.
- MISO capture:
  - Synchronized MISO is sampled in the last clk cycle of each sclk high phase.
  - Rising edges 7..16 yield B9..B0, MSB first. Earlier edges are ignored.
- CS_HOLD: cs_n is high for CLK_DIV cycles. Then the Y frame runs, identical except for the channel number.
- Timing: cs_n is low 33*CLK_DIV cycles per frame.
- PUBLISH:
  - Happens on the cycle cs_n rises after the Y frame, at t0+1+67*CLK_DIV.
  - digital_x and digital_y update together and sample_valid=1 for one cycle.
  - The FSM returns to IDLE, or to CS_SETUP if pending is set; pending clears.
- Between publishes, outputs hold their values.
- No arithmetic or scaling: the raw 10-bit codes are output.

Decomposition:
- Package joystick_pkg holds: the round state enum; the frame constants (FRAME_SCLKS=16, DATA_FIRST_EDGE=7, ADC_BITS=10); and the channel-select width.
- Sub-module spi_adc_frame performs one CS/SCLK/MOSI/MISO frame.
  - Inputs: start, channel.
  - Outputs: done, a 10-bit result, and the pin signals.
- The top level contains the timer, pending/overrun logic, the X-then-Y sequencing FSM, and the output registers.

Test Plan:
1. CLK_DIV=4, ADC model returns X=10'h2A5 and Y=10'h15A; pulse trigger at t0. Expect:
   - sample_valid at t0+269.
   - digital_x=10'h2A5, digital_y=10'h15A.
   - Decoded MOSI commands 11000 then 11001.
2. enable=1, SAMPLE_PERIOD=400, CLK_DIV=4. Expect sample_valid every 400 cycles and overrun=0. Drop enable mid-round: that round still publishes, then no further ticks.
3. Trigger twice while busy. Expect:
   - First extra trigger: a second round starts the cycle after sample_valid.
   - Second extra trigger: sets overrun=1, which stays high until rst.
4. Assert rst during the Y frame SHIFT. Expect cs_n=1, sclk=0, outputs=0 and busy=0 immediately. After release, a trigger yields a correct full round.
5. Model values 10'h000 and 10'h3FF, plus a MISO transition at every sclk falling edge. Expect exact capture, and check that sclk never toggles while cs_n=1.
6. Trigger and tick in the same cycle while IDLE. Expect exactly one round, pending=0, and overrun=0.

Source files
------------

// File: rtl/joystick_pkg.sv
// Shared types and frame constants for the joystick ADC scheduler.
package joystick_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      PUBLISH
   } round_state_t;

   localparam int FRAME_SCLKS     = 16;
   localparam int DATA_FIRST_EDGE = 7;
   localparam int ADC_BITS        = 10;
   localparam int CH_W            = 3;

   // sclk toggles per frame and width of the command bits after the start bit
   localparam int FRAME_TOGGLES   = 2 * FRAME_SCLKS;
   localparam int CMD_W           = CH_W + 2;

   // Command bits shifted out after the start bit: single-ended flag, channel, then zero
   function automatic logic [CMD_W-1:0] frame_cmd(input logic [CH_W-1:0] ch);
      return {1'b1, ch, 1'b0};
   endfunction

endpackage

// File: rtl/joystick_adc_scheduler_frame.sv
// One MCP3008-style SPI frame: chip select, mode-0 sclk, command out, 10-bit result in.
module spi_adc_frame
   import joystick_pkg::*;
#(
   parameter int CLK_DIV = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [CH_W-1:0]     channel,
   output logic                done,
   output logic [ADC_BITS-1:0] result,
   output logic                cs_n,
   output logic                sclk,
   output logic                mosi,
   input  logic                miso
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int TOG_W = $clog2(FRAME_TOGGLES + 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [TOG_W-1:0] TOG_END   = TOG_W'(FRAME_TOGGLES);
   // sclk high phase preceding the falling edge after rising edge DATA_FIRST_EDGE
   localparam logic [TOG_W-1:0] CAP_FIRST = TOG_W'(2 * DATA_FIRST_EDGE - 1);

   logic             active;
   logic [DIV_W-1:0] div_cnt;
   logic [TOG_W-1:0] tog_cnt;
   logic [CMD_W-1:0] cmd_sr;
   logic             miso_meta;
   logic             miso_sync;
   logic             launch;
   logic             phase_end;
   logic             capture;

   assign launch    = start && !active;
   assign phase_end = active && (div_cnt == DIV_LAST);
   // Event after the last toggle is the cs_n release, so done lines up with cs_n rising
   assign done      = phase_end && (tog_cnt == TOG_END);
   // Last clk cycle of an sclk high phase inside the data window
   assign capture   = phase_end && sclk && (tog_cnt >= CAP_FIRST);

   // Two-flop synchronizer for the asynchronous ADC data line
   always_ff @(posedge clk) begin
      miso_meta <= miso;
      miso_sync <= miso_meta;
   end

   // Frame sequencing: setup phase, 32 sclk toggles, then release chip select
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active  <= 1'b0;
         cs_n    <= 1'b1;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         div_cnt <= '0;
         tog_cnt <= '0;
         cmd_sr  <= '0;
      end else if (launch) begin
         active  <= 1'b1;
         cs_n    <= 1'b0;
         sclk    <= 1'b0;
         mosi    <= 1'b1;
         div_cnt <= '0;
         tog_cnt <= '0;
         cmd_sr  <= frame_cmd(channel);
      end else if (active) begin
         if (phase_end) begin
            div_cnt <= '0;
            if (tog_cnt == TOG_END) begin
               active <= 1'b0;
               cs_n   <= 1'b1;
               mosi   <= 1'b0;
            end else begin
               sclk    <= ~sclk;
               tog_cnt <= tog_cnt + 1'b1;
               // Next command bit goes out with each falling edge
               if (sclk) begin
                  mosi   <= cmd_sr[CMD_W-1];
                  cmd_sr <= {cmd_sr[CMD_W-2:0], 1'b0};
               end
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   // Result shift register, MSB first, cleared at frame launch
   always_ff @(posedge clk) begin
      if (launch) begin
         result <= '0;
      end else if (capture) begin
         result <= {result[ADC_BITS-2:0], miso_sync};
      end
   end

endmodule

// File: rtl/joystick_adc_scheduler.sv
// Joystick ADC scheduler: periodic/triggered rounds converting X then Y, published as a pair.
module joystick_adc_scheduler
   import joystick_pkg::*;
#(
   parameter int              CLK_DIV       = 8,
   parameter int              SAMPLE_PERIOD = 50000,
   parameter logic [CH_W-1:0] CH_X          = 3'd0,
   parameter logic [CH_W-1:0] CH_Y          = 3'd1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                trigger,
   output logic                adc_cs_n,
   output logic                adc_sclk,
   output logic                adc_mosi,
   input  logic                adc_miso,
   output logic [ADC_BITS-1:0] digital_x,
   output logic [ADC_BITS-1:0] digital_y,
   output logic                sample_valid,
   output logic                busy,
   output logic                overrun
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int TMR_W = $clog2(SAMPLE_PERIOD);
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(SAMPLE_PERIOD - 1);

   round_state_t        state;
   round_state_t        state_nx;
   logic [TMR_W-1:0]    tmr;
   logic                tick;
   logic                start_req;
   logic [DIV_W-1:0]    hold_cnt;
   logic                axis_y;
   logic                pending;
   logic                frame_start;
   logic                start_y;
   logic                latch_x;
   logic                publish;
   logic [CH_W-1:0]     frame_ch;
   logic                frame_done;
   logic [ADC_BITS-1:0] frame_result;
   logic [ADC_BITS-1:0] x_hold;

   assign tick      = enable && (tmr == PERIOD_LAST);
   // A tick and a trigger together are a single start event
   assign start_req = tick || trigger;
   assign frame_ch  = start_y ? CH_Y : CH_X;
   assign busy      = (state != IDLE);

   spi_adc_frame #(
      .CLK_DIV (CLK_DIV)
   ) u_frame (
      .clk     (clk),
      .rst     (rst),
      .start   (frame_start),
      .channel (frame_ch),
      .done    (frame_done),
      .result  (frame_result),
      .cs_n    (adc_cs_n),
      .sclk    (adc_sclk),
      .mosi    (adc_mosi),
      .miso    (adc_miso)
   );

   // Sample timer: free-runs while enabled, parked at zero otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr <= '0;
      end else if (!enable || tick) begin
         tmr <= '0;
      end else begin
         tmr <= tmr + 1'b1;
      end
   end

   // Round state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Round sequencing: X frame, chip-select hold, Y frame, publish
   always_comb begin
      state_nx    = state;
      frame_start = 1'b0;
      start_y     = 1'b0;
      latch_x     = 1'b0;
      publish     = 1'b0;
      case (state)
         IDLE: begin
            if (start_req) begin
               frame_start = 1'b1;
               state_nx    = CS_SETUP;
            end
         end
         CS_SETUP: begin
            if (hold_cnt == DIV_LAST) begin
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (frame_done) begin
               if (axis_y) begin
                  publish  = 1'b1;
                  state_nx = PUBLISH;
               end else begin
                  latch_x  = 1'b1;
                  state_nx = CS_HOLD;
               end
            end
         end
         CS_HOLD: begin
            if (hold_cnt == DIV_LAST) begin
               frame_start = 1'b1;
               start_y     = 1'b1;
               state_nx    = CS_SETUP;
            end
         end
         PUBLISH: begin
            if (pending || start_req) begin
               frame_start = 1'b1;
               state_nx    = CS_SETUP;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Phase counter restarts on every state change; it times setup and hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
      end else if (state_nx != state) begin
         hold_cnt <= '0;
      end else begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

   // Remember which axis the running frame belongs to
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         axis_y <= 1'b0;
      end else if (frame_start) begin
         axis_y <= start_y;
      end
   end

   // One-deep pending request; a request arriving with pending already set is lost
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
         overrun <= 1'b0;
      end else if (state == PUBLISH) begin
         // One request restarts the round now, a second one stays queued
         pending <= pending && start_req;
      end else if (state != IDLE && start_req) begin
         if (pending) begin
            overrun <= 1'b1;
         end else begin
            pending <= 1'b1;
         end
      end
   end

   // X result is parked until the Y frame completes so both publish together
   always_ff @(posedge clk) begin
      if (latch_x) begin
         x_hold <= frame_result;
      end
   end

   // Published pair and its one-cycle valid strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_valid <= 1'b0;
         digital_x    <= '0;
         digital_y    <= '0;
      end else begin
         sample_valid <= publish;
         if (publish) begin
            digital_x <= x_hold;
            digital_y <= frame_result;
         end
      end
   end

endmodule

// File: tb/tb_joystick_adc_scheduler.sv
// Self-checking bench for joystick_adc_scheduler with a behavioural MCP3008 model.
module tb_joystick_adc_scheduler;

   localparam int         CLK_DIV       = 4;
   localparam int         SAMPLE_PERIOD = 400;
   localparam logic [2:0] CH_X          = 3'd0;
   localparam logic [2:0] CH_Y          = 3'd1;
   localparam int         ROUND_LAT     = 1 + 67 * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       trigger;
   logic       adc_cs_n;
   logic       adc_sclk;
   logic       adc_mosi;
   logic       adc_miso;
   logic [9:0] digital_x;
   logic [9:0] digital_y;
   logic       sample_valid;
   logic       busy;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   // bench-side tracking
   int         cyc = 0;
   int         sv_cnt = 0;
   int         last_sv = 0;
   int         last_cs_fall = 0;
   int         viol = 0;
   int         cmd_seen = 0;
   logic       prev_cs;
   logic       prev_sclk;
   logic [19:0] exp_q[$];
   logic [4:0]  exp_cmd_q[$];

   // ADC model state
   logic [9:0] x_val = 10'h0;
   logic [9:0] y_val = 10'h0;
   int         rcnt = 0;
   int         nr = 0;
   int         cmd_cnt = 0;
   logic [4:0] mcmd = 5'd0;
   logic [4:0] last_cmd = 5'd0;
   logic [9:0] word = 10'h0;
   logic       m_prev_cs = 1'b1;
   logic       m_prev_sclk = 1'b0;

   always #5 clk = ~clk;

   joystick_adc_scheduler #(
      .CLK_DIV       (CLK_DIV),
      .SAMPLE_PERIOD (SAMPLE_PERIOD),
      .CH_X          (CH_X),
      .CH_Y          (CH_Y)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .trigger      (trigger),
      .adc_cs_n     (adc_cs_n),
      .adc_sclk     (adc_sclk),
      .adc_mosi     (adc_mosi),
      .adc_miso     (adc_miso),
      .digital_x    (digital_x),
      .digital_y    (digital_y),
      .sample_valid (sample_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   // MCP3008 model: decodes command on rising edges 1..5, shifts data out on falling edges
   always begin
      @(negedge clk);
      if (m_prev_cs && !adc_cs_n) begin
         rcnt     = 0;
         mcmd     = 5'd0;
         adc_miso = 1'b0;
      end else if (!adc_cs_n) begin
         if (!m_prev_sclk && adc_sclk) begin
            rcnt = rcnt + 1;
            if (rcnt <= 5) mcmd = {mcmd[3:0], adc_mosi};
            if (rcnt == 5) begin
               last_cmd = mcmd;
               cmd_cnt  = cmd_cnt + 1;
            end
         end else if (m_prev_sclk && !adc_sclk) begin
            nr   = rcnt + 1;
            word = (mcmd[2:0] == CH_X) ? x_val : y_val;
            if (nr >= 7 && nr <= 16) adc_miso = word[16 - nr];
            else adc_miso = ~adc_miso;
         end
      end
      m_prev_cs   = adc_cs_n;
      m_prev_sclk = adc_sclk;
   end

   // Advance one clock and run the scoreboard / pin monitors
   task automatic step();
      logic [19:0] e;
      logic [4:0]  ec;
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (prev_cs && !adc_cs_n) last_cs_fall = cyc;
      if (prev_cs && adc_cs_n && (adc_sclk !== prev_sclk)) viol = viol + 1;
      prev_cs   = adc_cs_n;
      prev_sclk = adc_sclk;
      if (sample_valid === 1'b1) begin
         sv_cnt  = sv_cnt + 1;
         last_sv = cyc;
         checks  = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL sample_unexpected: got x=%h y=%h, required no publish", digital_x, digital_y);
         end else begin
            e = exp_q.pop_front();
            if ({digital_x, digital_y} !== e) begin
               errors = errors + 1;
               $display("FAIL sample_data: got x=%h y=%h, required x=%h y=%h",
                        digital_x, digital_y, e[19:10], e[9:0]);
            end
         end
      end
      if (cmd_cnt != cmd_seen) begin
         cmd_seen = cmd_cnt;
         checks   = checks + 1;
         if (exp_cmd_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL mosi_cmd_unexpected: got %b", last_cmd);
         end else begin
            ec = exp_cmd_q.pop_front();
            if (last_cmd !== ec) begin
               errors = errors + 1;
               $display("FAIL mosi_cmd: got %b required %b", last_cmd, ec);
            end
         end
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic push_round(input logic [9:0] x, input logic [9:0] y);
      exp_q.push_back({x, y});
      exp_cmd_q.push_back({2'b11, CH_X});
      exp_cmd_q.push_back({2'b11, CH_Y});
   endtask

   task automatic wait_sv(input int budget, input string name);
      int base;
      int n;
      base = sv_cnt;
      n = 0;
      while (sv_cnt == base && n < budget) begin
         step();
         n = n + 1;
      end
      if (sv_cnt == base) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s: no sample_valid within %0d cycles", name, budget);
      end
   endtask

   task automatic pulse_trigger();
      trigger = 1'b1;
      step();
      trigger = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; trigger = 1'b0;
      prev_cs = 1'b1; prev_sclk = 1'b0;
      #1;
      checks = checks + 1;
      if ({adc_cs_n, adc_sclk, adc_mosi, sample_valid, busy, overrun} !== 6'b100000) begin
         errors = errors + 1;
         $display("FAIL reset_ctrl: got cs_n/sclk/mosi/valid/busy/ovr=%b required 100000",
                  {adc_cs_n, adc_sclk, adc_mosi, sample_valid, busy, overrun});
      end
      steps(3);
      checks = checks + 1;
      if ({digital_x, digital_y} !== 20'h0) begin
         errors = errors + 1;
         $display("FAIL reset_data: got x=%h y=%h required 0 0", digital_x, digital_y);
      end
      rst = 1'b0;
      steps(2);
   endtask

   task automatic test_single_round();
      int t0;
      x_val = 10'h2A5; y_val = 10'h15A;
      push_round(x_val, y_val);
      t0 = cyc;
      pulse_trigger();
      checks = checks + 1;
      if ({adc_cs_n, busy, adc_mosi} !== 3'b011) begin
         errors = errors + 1;
         $display("FAIL start_t0p1: got cs_n/busy/mosi=%b required 011", {adc_cs_n, busy, adc_mosi});
      end
      wait_sv(400, "single_round");
      checks = checks + 1;
      if (last_sv - t0 !== ROUND_LAT) begin
         errors = errors + 1;
         $display("FAIL round_latency: got %0d required %0d", last_sv - t0, ROUND_LAT);
      end
      step();
      checks = checks + 1;
      if ({busy, sample_valid, adc_cs_n} !== 3'b001) begin
         errors = errors + 1;
         $display("FAIL after_publish: got busy/valid/cs_n=%b required 001", {busy, sample_valid, adc_cs_n});
      end
   endtask

   task automatic test_timer();
      int e;
      int s1;
      int s2;
      int base;
      int n;
      x_val = 10'h1C3; y_val = 10'h0F0;
      for (int i = 0; i < 4; i++) push_round(x_val, y_val);
      base = sv_cnt;
      enable = 1'b1;
      e = cyc;
      wait_sv(800, "timer_first");
      checks = checks + 1;
      if (last_sv - e !== SAMPLE_PERIOD - 1 + ROUND_LAT) begin
         errors = errors + 1;
         $display("FAIL timer_first: got %0d required %0d", last_sv - e, SAMPLE_PERIOD - 1 + ROUND_LAT);
      end
      s1 = last_sv;
      for (int k = 0; k < 2; k++) begin
         wait_sv(500, "timer_next");
         s2 = last_sv;
         checks = checks + 1;
         if (s2 - s1 !== SAMPLE_PERIOD) begin
            errors = errors + 1;
            $display("FAIL timer_period: got %0d required %0d", s2 - s1, SAMPLE_PERIOD);
         end
         s1 = s2;
      end
      checks = checks + 1;
      if (overrun !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL timer_overrun: got %b required 0", overrun);
      end
      step();
      n = 0;
      while (busy !== 1'b1 && n < 500) begin step(); n = n + 1; end
      steps(20);
      enable = 1'b0;
      wait_sv(400, "timer_last_round");
      steps(1200);
      checks = checks + 1;
      if (sv_cnt - base !== 4) begin
         errors = errors + 1;
         $display("FAIL timer_rounds: got %0d required 4", sv_cnt - base);
      end
   endtask

   task automatic test_pending_overrun();
      int t0;
      int s1;
      x_val = 10'h0AB; y_val = 10'h354;
      push_round(x_val, y_val);
      push_round(x_val, y_val);
      t0 = cyc;
      pulse_trigger();
      steps(9);
      pulse_trigger();
      checks = checks + 1;
      if (overrun !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL pending_no_overrun: got %b required 0", overrun);
      end
      steps(9);
      pulse_trigger();
      checks = checks + 1;
      if (overrun !== 1'b1) begin
         errors = errors + 1;
         $display("FAIL overrun_set: got %b required 1", overrun);
      end
      wait_sv(400, "pending_first");
      s1 = last_sv;
      checks = checks + 1;
      if (s1 - t0 !== ROUND_LAT) begin
         errors = errors + 1;
         $display("FAIL pending_first_latency: got %0d required %0d", s1 - t0, ROUND_LAT);
      end
      step();
      checks = checks + 1;
      if ({adc_cs_n, busy} !== 2'b01 || last_cs_fall !== s1 + 1) begin
         errors = errors + 1;
         $display("FAIL pending_restart: got cs_n/busy=%b fall_at=%0d required 01 fall_at=%0d",
                  {adc_cs_n, busy}, last_cs_fall, s1 + 1);
      end
      wait_sv(400, "pending_second");
      checks = checks + 1;
      if (last_sv - s1 !== ROUND_LAT) begin
         errors = errors + 1;
         $display("FAIL pending_second_latency: got %0d required %0d", last_sv - s1, ROUND_LAT);
      end
      steps(50);
      checks = checks + 1;
      if (overrun !== 1'b1 || busy !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL overrun_sticky: got ovr/busy=%b%b required 10", overrun, busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      int t0;
      x_val = 10'h2F1; y_val = 10'h10E;
      push_round(x_val, y_val);
      t0 = cyc;
      pulse_trigger();
      while (cyc < t0 + 200) step();
      rst = 1'b1;
      #1;
      checks = checks + 1;
      if ({adc_cs_n, adc_sclk, busy, sample_valid, overrun} !== 5'b10000) begin
         errors = errors + 1;
         $display("FAIL midreset_ctrl: got cs_n/sclk/busy/valid/ovr=%b required 10000",
                  {adc_cs_n, adc_sclk, busy, sample_valid, overrun});
      end
      checks = checks + 1;
      if ({digital_x, digital_y} !== 20'h0) begin
         errors = errors + 1;
         $display("FAIL midreset_data: got x=%h y=%h required 0 0", digital_x, digital_y);
      end
      exp_q.delete();
      exp_cmd_q.delete();
      steps(2);
      rst = 1'b0;
      steps(3);
      x_val = 10'h3A7; y_val = 10'h05C;
      push_round(x_val, y_val);
      t0 = cyc;
      pulse_trigger();
      wait_sv(400, "after_reset_round");
      checks = checks + 1;
      if (last_sv - t0 !== ROUND_LAT) begin
         errors = errors + 1;
         $display("FAIL after_reset_latency: got %0d required %0d", last_sv - t0, ROUND_LAT);
      end
      steps(3);
   endtask

   task automatic test_extremes();
      x_val = 10'h000; y_val = 10'h3FF;
      push_round(x_val, y_val);
      pulse_trigger();
      wait_sv(400, "extreme_a");
      steps(3);
      x_val = 10'h3FF; y_val = 10'h000;
      push_round(x_val, y_val);
      pulse_trigger();
      wait_sv(400, "extreme_b");
      steps(3);
      checks = checks + 1;
      if (viol !== 0) begin
         errors = errors + 1;
         $display("FAIL sclk_while_cs_high: got %0d toggles required 0", viol);
      end
   endtask

   task automatic test_same_cycle_events();
      int e;
      int base;
      x_val = 10'h1A5; y_val = 10'h25A;
      push_round(x_val, y_val);
      base = sv_cnt;
      enable = 1'b1;
      e = cyc;
      while (cyc < e + SAMPLE_PERIOD - 1) step();
      pulse_trigger();
      wait_sv(400, "same_cycle");
      checks = checks + 1;
      if (last_sv - (e + SAMPLE_PERIOD - 1) !== ROUND_LAT) begin
         errors = errors + 1;
         $display("FAIL same_cycle_latency: got %0d required %0d",
                  last_sv - (e + SAMPLE_PERIOD - 1), ROUND_LAT);
      end
      while (cyc < e + 700) step();
      enable = 1'b0;
      steps(600);
      checks = checks + 1;
      if (sv_cnt - base !== 1 || overrun !== 1'b0 || busy !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL same_cycle_single: got rounds=%0d ovr=%b busy=%b required 1 0 0",
                  sv_cnt - base, overrun, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single_round();
      test_timer();
      test_pending_overrun();
      test_reset_mid_frame();
      test_extremes();
      test_same_cycle_events();
      checks = checks + 1;
      if (exp_q.size() != 0 || exp_cmd_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL leftover_expected: got %0d samples %0d cmds outstanding required 0 0",
                  exp_q.size(), exp_cmd_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
